// File: rtl/pc_seq_ctrl.sv
// Fetch/next-PC sequencer: owns the architectural PC, runs the instruction-memory
// req/ack handshake and picks the next PC by fixed redirect priority.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        mret,
    input  logic        trap_req,
    output logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic [31:0] epc,
    output logic [1:0]  trap_cause
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        misaligned;
    logic        commit;
    logic [31:0] jump_pc;

    // jal/jalr clear bit 0; a set bit 1 is still an unaligned target
    assign jump_pc    = jump_target & ~32'h1;
    assign misaligned = (jump_en && jump_target[1]) ||
                        (!jump_en && branch_taken && (branch_target[1:0] != 2'b00));
    assign commit     = (state == EXEC) && !stall;

    always_comb begin
        pc_next = pc_cur + 32'd4;
        if (trap_req) begin
            pc_next = TRAP_VECTOR;
        end else if (misaligned) begin
            pc_next = TRAP_VECTOR;
        end else if (mret) begin
            pc_next = epc;
        end else if (jump_en) begin
            pc_next = jump_pc;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        imem_addr   = pc_cur;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Trap bookkeeping only moves when an instruction actually retires its redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_cur     <= RESET_VECTOR;
            epc        <= 32'h0;
            trap_cause <= 2'd0;
        end else if (commit) begin
            pc_cur <= pc_next;
            if (trap_req) begin
                epc        <= pc_cur;
                trap_cause <= 2'd1;
            end else if (misaligned) begin
                epc        <= pc_cur;
                trap_cause <= 2'd2;
            end else if (mret) begin
                trap_cause <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: the driver queues expected fetch addresses and
// committed next-PCs, a negedge monitor pops and compares them as the DUT presents them.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        mret;
    logic        trap_req;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_load;
    logic [31:0] epc;
    logic [1:0]  trap_cause;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] fetch_q[$];
    logic [31:0] commit_q[$];

    pc_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target),
        .mret(mret), .trap_req(trap_req),
        .pc_cur(pc_cur), .pc_next(pc_next), .pc_load(pc_load),
        .epc(epc), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted fetch and every committed PC is matched against the queues
    always @(negedge clk) begin
        if (rst) begin
            if (imem_req && imem_ack) begin
                if (fetch_q.size() == 0) checkOutput("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
                else checkOutput("fetch_addr", imem_addr, fetch_q.pop_front());
            end
            if (pc_load) begin
                if (commit_q.size() == 0) checkOutput("unexpected_commit", pc_next, 32'hDEAD_BEEF);
                else checkOutput("commit_pc_next", pc_next, commit_q.pop_front());
            end
        end
    end

    task automatic clearControls();
        stall = 0; branch_taken = 0; branch_target = 0; jump_en = 0;
        jump_target = 0; mret = 0; trap_req = 0;
    endtask

    // Runs one fetch/execute pass; called at posedge+1 with the DUT in FETCH
    task automatic applyStimulus(input int ack_delay, input logic [31:0] exp_fetch,
                                 input int stall_cycles, input logic tr,
                                 input logic jmp, input logic [31:0] jt,
                                 input logic br, input logic [31:0] bt, input logic mr,
                                 input logic [31:0] exp_next, input logic [31:0] exp_epc,
                                 input logic [1:0] exp_cause);
        bit seen = 0;
        fetch_q.push_back(exp_fetch);
        commit_q.push_back(exp_next);
        imem_ack = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checkOutput("req_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < ack_delay; i++) begin
            checkOutput("wait_req", {31'd0, imem_req}, 32'd1);
            checkOutput("wait_addr", imem_addr, exp_fetch);
            checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(posedge clk); #1;
        end
        imem_ack = 1;
        @(posedge clk); #1;
        imem_ack = 0;
        for (int i = 0; i < stall_cycles; i++) begin
            stall = 1; trap_req = 1;
            #1;
            checkOutput("stall_pc_load", {31'd0, pc_load}, 32'd0);
            checkOutput("stall_pc_cur", pc_cur, exp_fetch);
            @(posedge clk); #1;
        end
        stall = 0; trap_req = tr; jump_en = jmp; jump_target = jt;
        branch_taken = br; branch_target = bt; mret = mr;
        #1;
        checkOutput("exec_valid", {31'd0, instr_valid}, 32'd1);
        @(posedge clk); #1;
        clearControls();
        checkOutput("pc_after", pc_cur, exp_next);
        checkOutput("epc", epc, exp_epc);
        checkOutput("trap_cause", {30'd0, trap_cause}, {30'd0, exp_cause});
    endtask

    task automatic checkResetState();
        checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_pc_load", {31'd0, pc_load}, 32'd0);
        checkOutput("rst_pc_cur", pc_cur, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
        checkOutput("rst_trap_cause", {30'd0, trap_cause}, 32'd0);
    endtask

    initial begin
        clearControls();
        imem_ack = 1;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        rst = 1;
        #1;
        checkOutput("boot_idle", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        checkOutput("boot_then_fetch", {31'd0, imem_req}, 32'd1);

        //           dly  fetch         stl tr jmp jt             br bt          mr next          epc          cause
        applyStimulus(0, 32'h0000_0000, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0004, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_0004, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0008, 32'h0,       2'd0);
        applyStimulus(3, 32'h0000_0008, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_000C, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_000C, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0010, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_0010, 0, 0, 1, 32'h41,        1, 32'h80,    0, 32'h0000_0040, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_0040, 0, 0, 1, 32'h10,        0, 32'h0,     0, 32'h0000_0010, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_0010, 0, 0, 0, 32'h0,         1, 32'h22,    0, 32'h0000_0100, 32'h10,      2'd2);
        applyStimulus(0, 32'h0000_0100, 0, 0, 1, 32'h24,        0, 32'h0,     0, 32'h0000_0024, 32'h10,      2'd2);
        applyStimulus(0, 32'h0000_0024, 0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0100, 32'h24,      2'd1);
        applyStimulus(0, 32'h0000_0100, 0, 0, 0, 32'h0,         0, 32'h0,     1, 32'h0000_0024, 32'h24,      2'd0);
        applyStimulus(0, 32'h0000_0024, 5, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0028, 32'h24,      2'd0);
        applyStimulus(0, 32'h0000_0028, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,     0, 32'hFFFF_FFFC, 32'h24,      2'd0);
        applyStimulus(0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0000, 32'h24,      2'd0);
        applyStimulus(0, 32'h0000_0000, 0, 0, 1, 32'h42,        0, 32'h0,     0, 32'h0000_0100, 32'h0,       2'd2);
        applyStimulus(0, 32'h0000_0100, 0, 0, 0, 32'h0,         0, 32'h0,     1, 32'h0000_0000, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_0000, 0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0100, 32'h0,       2'd1);
        applyStimulus(0, 32'h0000_0100, 0, 0, 0, 32'h0,         0, 32'h0,     1, 32'h0000_0000, 32'h0,       2'd0);
        applyStimulus(0, 32'h0000_0000, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0004, 32'h0,       2'd0);

        // Move epc away from zero so the reset value is visible, then reset mid-fetch
        applyStimulus(0, 32'h0000_0004, 0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0100, 32'h4,       2'd1);
        imem_ack = 0;
        @(posedge clk); #1;
        checkOutput("midfetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("midfetch_addr", imem_addr, 32'h100);
        #2;
        rst = 0;
        #1;
        checkResetState();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
        checkOutput("reboot_idle", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0000_0000, 0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0000_0004, 32'h0,       2'd0);

        @(posedge clk); #1;
        checkOutput("fetch_q_drained", fetch_q.size(), 32'd0);
        checkOutput("commit_q_drained", commit_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Fetch/next-PC sequencer for the RISC-V core. It owns the architectural PC and runs instruction memory through a req/ack handshake. It selects the next PC by fixed priority: trap, misaligned-target trap, mret, jump, branch, sequential. It drives the program counter's load value and holds the PC while the core stalls.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded on any trap.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; equals pc_cur while imem_req=1.
imem_ack  in  1  memory accepted request and returned instruction this cycle.
instr_valid  out  1  fetched instruction is being executed; control inputs are sampled.
stall  in  1  hold the current instruction; no PC update.
branch_taken  in  1  conditional branch resolved taken.
branch_target  in  32  branch destination.
jump_en  in  1  jal/jalr.
jump_target  in  32  jump destination; bit0 forced to 0 internally.
mret  in  1  return from trap.
trap_req  in  1  ecall/ebreak/illegal-instruction trap.
pc_cur  out  32  PC of the instruction being fetched or executed.
pc_next  out  32  combinational next PC; drives the program counter load input.
pc_load  out  1  pc_next is committed this cycle.
epc  out  32  saved PC of the trapping instruction.
trap_cause  out  2  0=none, 1=trap_req, 2=misaligned target; sticky until next trap or mret.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; pc_cur=RESET_VECTOR; epc=0; trap_cause=0.
  - imem_req, instr_valid and pc_load drop to 0 immediately, including mid-fetch.
- States: BOOT, FETCH, EXEC.
- BOOT: lasts exactly one cycle after reset release; outputs idle; next state FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_cur.
  - imem_ack=0: remain in FETCH with the address held stable.
  - imem_ack=1: go to EXEC next cycle. Fetch latency from first req cycle to EXEC is 1 cycle when ack arrives in the same cycle.
  - Control inputs (stall, branch, jump, mret, trap) are ignored in FETCH.
- EXEC:
  - instr_valid=1 and imem_req=0; imem_ack is ignored.
  - stall=1: remain in EXEC with pc_load=0 and pc_cur unchanged. stall has priority over every redirect, including trap_req.
  - stall=0: pc_load=1 for one cycle, pc_cur<=pc_next, then go to FETCH.
- pc_next priority, evaluated every cycle (only committed in EXEC with stall=0):
  1. trap_req: TRAP_VECTOR; epc<=pc_cur; trap_cause<=1.
  2. jump_en with jump_target[1] != 0, or branch_taken (when not jumping) with branch_target[1:0] != 0: TRAP_VECTOR; epc<=pc_cur; trap_cause<=2.
  3. mret: epc; trap_cause<=0.
  4. jump_en: {jump_target[31:1],1'b0}.
  5. branch_taken: branch_target.
  6. Otherwise: pc_cur+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Simultaneous inputs: the highest priority wins and the others are dropped for that instruction. For example, jump_en and branch_taken together take the jump target.
- pc_next is also valid (equals the selection above) outside EXEC, but pc_load is 0 there.
- epc and trap_cause change only on committed traps or mret.

Test Plan:
- Reset/boot: hold rst=0 for 3 cycles, release; ack tied 1 -> BOOT 1 cycle, imem_req=1 with imem_addr=0, EXEC next, then pc_cur sequence 0, 4, 8, 12.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr=0x8 held stable for all 4 cycles; instr_valid asserts only after the ack.
- Redirects: at pc=0x10 assert jump_en, jump_target=0x41 and branch_taken together -> next fetch at 0x40. Separately, branch_target=0x22 -> fetch at TRAP_VECTOR=0x100, epc=0x10, trap_cause=2.
- Trap/mret: trap_req at pc=0x24 -> fetch at 0x100, epc=0x24, trap_cause=1; later mret -> fetch at 0x24, trap_cause=0.
- Stall and wrap: stall=1 for 5 EXEC cycles together with trap_req -> pc_load=0 throughout and pc unchanged. Separately, pc=0xFFFF_FFFC sequential -> next fetch at 0x0.
- Reset mid-fetch: drop rst while in FETCH waiting on ack -> imem_req=0 in the same cycle (asynchronous), pc_cur=RESET_VECTOR, BOOT on release.
